// File: rtl/vc_bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
// Holds the default data width, the derived field widths and the FSM state encoding.
package vc_bus_pkg;
  localparam int RV_DEF = 16;
  localparam int AW = RV_DEF - RV_DEF / 16;
  localparam int MW = RV_DEF / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;
endpackage

// File: rtl/vc_bus_arbiter.sv
// Round-robin arbiter between the CPU (m0) and the debug/loader port (m1) in front of the bus sequencer.
// It registers the winning request, holds it for the whole transaction and returns done only to the winner.
module vc_bus_arbiter
  import vc_bus_pkg::*;
#(
  parameter int RV = RV_DEF
) (
  input  logic                 clk,
  input  logic                 r_reset,
  input  logic [RV-1:RV/16]    m0_raddr,
  input  logic                 m0_rreq,
  output logic                 m0_rdone,
  input  logic [RV-1:RV/16]    m0_waddr,
  input  logic [RV/8-1:0]      m0_wmask,
  input  logic [RV-1:0]        m0_wdata,
  output logic                 m0_wdone,
  input  logic [RV-1:RV/16]    m1_raddr,
  input  logic                 m1_rreq,
  output logic                 m1_rdone,
  input  logic [RV-1:RV/16]    m1_waddr,
  input  logic [RV/8-1:0]      m1_wmask,
  input  logic [RV-1:0]        m1_wdata,
  output logic                 m1_wdone,
  output logic [RV-1:0]        rdata,
  output logic [RV-1:RV/16]    s_raddr,
  output logic                 s_rreq,
  output logic [RV-1:RV/16]    s_waddr,
  output logic [RV/8-1:0]      s_wmask,
  output logic [RV-1:0]        s_wdata,
  input  logic [RV-1:0]        s_rdata,
  input  logic                 s_rdone,
  input  logic                 s_wdone
);

  state_t                state_reg, state_next;
  logic                  ptr_reg, ptr_next;
  logic                  grant_reg, grant_next;
  logic                  wr_reg, wr_next;
  logic                  s_rreq_reg, s_rreq_next;
  logic [RV/8-1:0]       s_wmask_reg, s_wmask_next;
  logic [RV-1:RV/16]     s_raddr_reg, s_raddr_next;
  logic [RV-1:RV/16]     s_waddr_reg, s_waddr_next;
  logic [RV-1:0]         s_wdata_reg, s_wdata_next;

  logic [RV-1:RV/16]     raddr_v [2];
  logic [RV-1:RV/16]     waddr_v [2];
  logic [RV/8-1:0]       wmask_v [2];
  logic [RV-1:0]         wdata_v [2];
  logic [1:0]            rreq_v;
  logic [1:0]            pend;
  logic [1:0]            rdone_v, wdone_v;
  logic                  win;

  assign raddr_v[0] = m0_raddr;
  assign raddr_v[1] = m1_raddr;
  assign waddr_v[0] = m0_waddr;
  assign waddr_v[1] = m1_waddr;
  assign wmask_v[0] = m0_wmask;
  assign wmask_v[1] = m1_wmask;
  assign wdata_v[0] = m0_wdata;
  assign wdata_v[1] = m1_wdata;
  assign rreq_v     = {m1_rreq, m0_rreq};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign pend[gi]    = rreq_v[gi] | (|wmask_v[gi]);
      // Done is forwarded only in BUSY, only of the granted type, only to the granted master.
      assign rdone_v[gi] = (state_reg == ST_BUSY) && !wr_reg && s_rdone && (grant_reg == 1'(gi));
      assign wdone_v[gi] = (state_reg == ST_BUSY) &&  wr_reg && s_wdone && (grant_reg == 1'(gi));
    end
  endgenerate

  // On a tie the master not granted last wins; ptr_reg holds the last grant.
  assign win = pend[1] & (~pend[0] | ~ptr_reg);

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    grant_next   = grant_reg;
    wr_next      = wr_reg;
    s_rreq_next  = s_rreq_reg;
    s_wmask_next = s_wmask_reg;
    s_raddr_next = s_raddr_reg;
    s_waddr_next = s_waddr_reg;
    s_wdata_next = s_wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|pend) begin
          s_raddr_next = raddr_v[win];
          s_waddr_next = waddr_v[win];
          s_wdata_next = wdata_v[win];
          wr_next      = |wmask_v[win];
          s_wmask_next = wmask_v[win];
          s_rreq_next  = ~(|wmask_v[win]);
          ptr_next     = win;
          grant_next   = win;
          state_next   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if ((wr_reg && s_wdone) || (!wr_reg && s_rdone)) begin
          s_rreq_next  = 1'b0;
          s_wmask_next = '0;
          state_next   = ST_RELEASE;
        end
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_reset) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= 1'b1;
      grant_reg   <= 1'b0;
      wr_reg      <= 1'b0;
      s_rreq_reg  <= 1'b0;
      s_wmask_reg <= '0;
      s_raddr_reg <= '0;
      s_waddr_reg <= '0;
      s_wdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      grant_reg   <= grant_next;
      wr_reg      <= wr_next;
      s_rreq_reg  <= s_rreq_next;
      s_wmask_reg <= s_wmask_next;
      s_raddr_reg <= s_raddr_next;
      s_waddr_reg <= s_waddr_next;
      s_wdata_reg <= s_wdata_next;
    end
  end

  assign m0_rdone = rdone_v[0];
  assign m1_rdone = rdone_v[1];
  assign m0_wdone = wdone_v[0];
  assign m1_wdone = wdone_v[1];
  assign rdata    = s_rdata;
  assign s_rreq   = s_rreq_reg;
  assign s_wmask  = s_wmask_reg;
  assign s_raddr  = s_raddr_reg;
  assign s_waddr  = s_waddr_reg;
  assign s_wdata  = s_wdata_reg;

endmodule
